bypass_net: RTL and testbench

- Parametrised operand-forwarding and hazard unit for the in-order integer pipeline.
- Sits between register-file read and the execute stage.
- For each of NREAD read ports, selects the youngest in-flight result from NSTAGE producer stages, or falls back to register-file data.
- Tracks long-latency writes (loads, mul/div) in a sequential pending scoreboard, asserts stall on unresolved hazards, and counts stall cycles for performance monitoring.

---
 rtl/bypass_net.sv | 115 +++++++++++
 tb/tb_bypass_net.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bypass_net.sv
// bypass_net: operand forwarding, long-latency pending scoreboard and
// stall generation between register-file read and execute.
module bypass_net #(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned CW     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD-1:0]        rd_en,
    input  logic [NREAD*AW-1:0]     rd_addr,
    input  logic [NREAD*DW-1:0]     rf_data,
    input  logic [NSTAGE-1:0]       src_wen,
    input  logic [NSTAGE*AW-1:0]    src_addr,
    input  logic [NSTAGE*DW-1:0]    src_data,
    input  logic [NSTAGE-1:0]       src_ready,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_addr,
    input  logic                    wb_valid,
    input  logic [AW-1:0]           wb_addr,
    input  logic                    flush,
    output logic [NREAD*DW-1:0]     fwd_data,
    output logic [NREAD-1:0]        fwd_hit,
    output logic                    stall,
    output logic [CW-1:0]           stall_cnt,
    output logic [(1<<AW)-1:0]      pending
);

    localparam int unsigned NREG = 1 << AW;

    logic [NREAD-1:0] port_haz;
    logic [NREG-1:0]  pending_nxt;
    logic [AW-1:0]    raddr;
    logic             found;
    logic             win_ready;
    logic [DW-1:0]    win_data;

    // Per-port youngest-match selection and hazard detection (zero latency).
    always_comb begin
        fwd_data  = '0;
        fwd_hit   = '0;
        port_haz  = '0;
        raddr     = '0;
        found     = 1'b0;
        win_ready = 1'b0;
        win_data  = '0;
        for (int i = 0; i < NREAD; i++) begin
            raddr     = rd_addr[i*AW +: AW];
            found     = 1'b0;
            win_ready = 1'b0;
            win_data  = rf_data[i*DW +: DW];
            // First hit from stage 0 upward is the youngest producer.
            for (int s = 0; s < NSTAGE; s++) begin
                if (!found && src_wen[s] && (src_addr[s*AW +: AW] == raddr)) begin
                    found     = 1'b1;
                    win_ready = src_ready[s];
                    win_data  = src_data[s*DW +: DW];
                end
            end
            // Register 0 is hardwired zero: never forwarded, never a hazard.
            if (raddr == '0) begin
                found     = 1'b0;
                win_ready = 1'b0;
                win_data  = '0;
            end
            fwd_data[i*DW +: DW] = win_data;
            fwd_hit[i]           = found;
            // A matching stage supersedes the scoreboard; only its readiness matters.
            if (rd_en[i] && (raddr != '0)) begin
                port_haz[i] = found ? !win_ready : pending[raddr];
            end
        end
    end

    // Stall whenever any enabled port has an unresolved operand.
    always_comb begin
        stall = |port_haz;
    end

    // Next scoreboard state: clear on writeback, set on accepted issue (set wins), flush wipes all.
    always_comb begin
        pending_nxt = pending;
        if (wb_valid) begin
            pending_nxt[wb_addr] = 1'b0;
        end
        if (issue_valid && !stall) begin
            pending_nxt[issue_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
        if (flush) begin
            pending_nxt = '0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Saturating stall-cycle counter; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_bypass_net.sv
// tb_bypass_net: directed vectors with hand-computed expectations for bypass_net.
module tb_bypass_net;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;
    localparam int unsigned NS = 3;
    localparam int unsigned CW = 4;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rf_data;
    logic [NS-1:0]     src_wen;
    logic [NS*AW-1:0]  src_addr;
    logic [NS*DW-1:0]  src_data;
    logic [NS-1:0]     src_ready;
    logic              issue_valid;
    logic [AW-1:0]     issue_addr;
    logic              wb_valid;
    logic [AW-1:0]     wb_addr;
    logic              flush;
    logic [NR*DW-1:0]  fwd_data;
    logic [NR-1:0]     fwd_hit;
    logic              stall;
    logic [CW-1:0]     stall_cnt;
    logic [(1<<AW)-1:0] pending;

    int vectors;
    int miscompares;

    bypass_net #(.DW(DW), .AW(AW), .NREAD(NR), .NSTAGE(NS), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rf_data(rf_data),
        .src_wen(src_wen), .src_addr(src_addr), .src_data(src_data), .src_ready(src_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
        .fwd_data(fwd_data), .fwd_hit(fwd_hit), .stall(stall),
        .stall_cnt(stall_cnt), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int i, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rd_en[i]             = en;
        rd_addr[i*AW +: AW]  = a;
        rf_data[i*DW +: DW]  = d;
    endtask

    task automatic set_src(input int s, input logic wen, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic rdy);
        src_wen[s]            = wen;
        src_addr[s*AW +: AW]  = a;
        src_data[s*DW +: DW]  = d;
        src_ready[s]          = rdy;
    endtask

    task automatic clear_inputs();
        rd_en = '0; rd_addr = '0; rf_data = '0;
        src_wen = '0; src_addr = '0; src_data = '0; src_ready = '0;
        issue_valid = 1'b0; issue_addr = '0;
        wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clear_inputs();
        rst = 1'b1;
        #1;
        check("reset_pending", 64'(pending), 64'h0);
        check("reset_cnt", 64'(stall_cnt), 64'h0);
        check("reset_stall", 64'(stall), 64'h0);
        step();
        step();
        rst = 1'b0;
        #1;

        // Youngest-stage priority
        set_rd(0, 1'b1, 5'd5, 32'h1111);
        set_rd(1, 1'b1, 5'd6, 32'h2222);
        set_src(0, 1'b1, 5'd5, 32'hAAAA, 1'b1);
        set_src(2, 1'b1, 5'd5, 32'hBBBB, 1'b1);
        #1;
        check("fwd0_young", 64'(fwd_data[31:0]), 64'hAAAA);
        check("hit0_young", 64'(fwd_hit[0]), 64'h1);
        check("stall_fwd", 64'(stall), 64'h0);
        check("fwd1_rf", 64'(fwd_data[63:32]), 64'h2222);
        check("hit1_rf", 64'(fwd_hit[1]), 64'h0);
        src_wen[0] = 1'b0;
        #1;
        check("fwd0_old", 64'(fwd_data[31:0]), 64'hBBBB);

        // Load-use hazard
        clear_inputs();
        set_rd(1, 1'b1, 5'd7, 32'h0);
        set_src(0, 1'b1, 5'd7, 32'h77, 1'b0);
        #1;
        check("loaduse_stall", 64'(stall), 64'h1);
        step(); step(); step();
        check("loaduse_cnt", 64'(stall_cnt), 64'h3);
        src_ready[0] = 1'b1;
        #1;
        check("ready_stall", 64'(stall), 64'h0);
        check("ready_fwd1", 64'(fwd_data[63:32]), 64'h77);
        step();
        check("ready_cnt_hold", 64'(stall_cnt), 64'h3);

        // Long-latency scoreboard
        clear_inputs();
        issue_valid = 1'b1; issue_addr = 5'd9;
        step();
        issue_valid = 1'b0;
        check("issue9_pending", 64'(pending), 64'h200);
        set_rd(0, 1'b1, 5'd9, 32'h9999);
        wb_valid = 1'b1; wb_addr = 5'd9;
        #1;
        check("pend9_stall", 64'(stall), 64'h1);
        step();
        wb_valid = 1'b0;
        #1;
        check("wb9_pending", 64'(pending), 64'h0);
        check("wb9_stall", 64'(stall), 64'h0);
        check("wb9_cnt", 64'(stall_cnt), 64'h4);

        // Issue while stalled is dropped
        clear_inputs();
        set_rd(1, 1'b1, 5'd7, 32'h0);
        set_src(0, 1'b1, 5'd7, 32'h0, 1'b0);
        issue_valid = 1'b1; issue_addr = 5'd10;
        step();
        check("issue_stalled_pend", 64'(pending), 64'h0);
        check("issue_stalled_cnt", 64'(stall_cnt), 64'h5);

        // Register 0
        clear_inputs();
        set_rd(0, 1'b1, 5'd0, 32'hFFFF);
        set_rd(1, 1'b1, 5'd0, 32'hFFFF);
        set_src(0, 1'b1, 5'd0, 32'h1234, 1'b0);
        issue_valid = 1'b1; issue_addr = 5'd0;
        #1;
        check("x0_fwd", 64'(fwd_data), 64'h0);
        check("x0_hit", 64'(fwd_hit), 64'h0);
        check("x0_stall", 64'(stall), 64'h0);
        step();
        check("x0_pending", 64'(pending), 64'h0);

        // Same-cycle set/clear, then flush
        clear_inputs();
        issue_valid = 1'b1; issue_addr = 5'd3;
        wb_valid = 1'b1; wb_addr = 5'd3;
        step();
        check("setwins_pending", 64'(pending), 64'h8);
        flush = 1'b1; issue_addr = 5'd4; wb_addr = 5'd3;
        step();
        clear_inputs();
        check("flush_pending", 64'(pending), 64'h0);

        // Async reset in the middle of a stall
        issue_valid = 1'b1; issue_addr = 5'd12;
        step();
        issue_valid = 1'b0;
        set_rd(0, 1'b1, 5'd12, 32'h0);
        #1;
        check("pend12_stall", 64'(stall), 64'h1);
        step();
        check("pend12_cnt", 64'(stall_cnt), 64'h6);
        rst = 1'b1;
        #1;
        check("midrst_pending", 64'(pending), 64'h0);
        check("midrst_cnt", 64'(stall_cnt), 64'h0);
        check("midrst_stall", 64'(stall), 64'h0);
        step();
        rst = 1'b0;

        // Counter saturation
        clear_inputs();
        set_rd(0, 1'b1, 5'd7, 32'h0);
        set_src(0, 1'b1, 5'd7, 32'h0, 1'b0);
        repeat (14) step();
        check("sat_cnt14", 64'(stall_cnt), 64'hE);
        repeat (5) step();
        check("sat_cnt15", 64'(stall_cnt), 64'hF);
        clear_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_keeps_cnt", 64'(stall_cnt), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
